mem_block_copy: RTL

Block-copy initiator that drives the single-port synchronous RAM as its master. It copies `len` consecutive 16-bit words from `src` to `dst` in ascending address order, absorbing the RAM's one-cycle registered read latency. It sits between the control/CPU side, which issues copy commands, and the RAM's address, write-enable, write-data and read-data port.

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_block_copy.sv | 61 ++++++
 2 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state type for the block-copy initiator.
package mem_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} copy_state_t;
endpackage

// File: rtl/mem_block_copy.sv
// mem_block_copy: copies len words from src to dst through a single-port RAM with 1-cycle read latency.
module mem_block_copy
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    copy_state_t state, state_nx;
    logic [ADDR_W-1:0] src_q, dst_q, len_q;
    logic last;
    // words_done doubles as the word index: both clear on start and advance per write
    assign last = (words_done + ADDR_W'(1)) == len_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ((len == '0) ? FIN : RD) : IDLE;
            RD:      state_nx = abort ? FIN : WR;
            WR:      state_nx = (abort || last) ? FIN : RD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            words_done <= '0;
        end else if (state == IDLE && start) begin
            src_q      <= src;
            dst_q      <= dst;
            len_q      <= len;
            words_done <= '0;
        end else if (state == WR) begin
            words_done <= words_done + ADDR_W'(1);
        end
    end
    assign mem_addr  = (state == RD) ? src_q + words_done : (state == WR) ? dst_q + words_done : '0;
    assign mem_we    = state == WR;
    assign mem_wdata = mem_rdata;
    assign busy      = state == RD || state == WR;
    assign done      = state == FIN;
endmodule
